// File: rtl/rpn_button_conditioner.sv
// rpn_button_conditioner: synchronises, debounces and serialises push-buttons into
// one-hot single-cycle CPU commands, with the switch value captured per push.
module rpn_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [3:0] RawBtns,
    input  logic [7:0] RawDin,
    input  logic       Turbo,
    output logic       Sample,
    output logic [2:0] Btns,
    output logic [7:0] DinOut,
    output logic [3:0] Pressed
);
    logic [3:0]       btn_s1, btn_s2;
    logic [7:0]       din_s1, din_s2;
    logic             turbo_s1, turbo_s2;
    logic [3:0]       stable, stable_nx, rise, pend, pend_nx, issue;
    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W-1:0] cnt_nx [4];
    logic [7:0]       din_hold;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            din_s1   <= '0;
            din_s2   <= '0;
            turbo_s1 <= 1'b0;
            turbo_s2 <= 1'b0;
        end else begin
            btn_s1   <= RawBtns;
            btn_s2   <= btn_s1;
            din_s1   <= RawDin;
            din_s2   <= din_s1;
            turbo_s1 <= Turbo;
            turbo_s2 <= turbo_s1;
        end
    end

    // A level is accepted only after it differs from stable for DEBOUNCE_CYCLES cycles
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stable_nx[i] = stable[i];
            cnt_nx[i]    = '0;
            if (turbo_s2)
                stable_nx[i] = btn_s2[i];
            else if (btn_s2[i] != stable[i]) begin
                if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1))
                    stable_nx[i] = btn_s2[i];
                else
                    cnt_nx[i] = cnt[i] + CNT_W'(1);
            end
        end
        rise    = stable_nx & ~stable;
        pend_nx = pend | rise;
        issue   = pend_nx[3] ? 4'b1000 :
                  pend_nx[2] ? 4'b0100 :
                  pend_nx[1] ? 4'b0010 :
                  pend_nx[0] ? 4'b0001 : 4'b0000;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            stable   <= '0;
            pend     <= '0;
            Sample   <= 1'b0;
            Btns     <= '0;
            din_hold <= '0;
            DinOut   <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            stable <= stable_nx;
            cnt    <= cnt_nx;
            pend   <= pend_nx & ~issue;
            Sample <= issue[3];
            Btns   <= issue[2:0];
            if (rise[3]) din_hold <= din_s2;
            // a push recognised and issued in the same cycle bypasses din_hold
            if (issue[3]) DinOut <= rise[3] ? din_s2 : din_hold;
        end
    end

    assign Pressed = stable;
endmodule

// File: tb/tb_rpn_button_conditioner.sv
// tb_rpn_button_conditioner: table-driven Turbo vectors plus hand-written debounce,
// data-capture and reset sequences; expected pulses are scoreboarded by cycle.
module tb_rpn_button_conditioner;
    logic       clk, Reset, Turbo, Sample;
    logic [3:0] RawBtns, Pressed;
    logic [7:0] RawDin, DinOut;
    logic [2:0] Btns;

    rpn_button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .Reset(Reset), .RawBtns(RawBtns), .RawDin(RawDin), .Turbo(Turbo),
        .Sample(Sample), .Btns(Btns), .DinOut(DinOut), .Pressed(Pressed)
    );

    typedef struct {int cyc; logic [3:0] code; logic [7:0] din;} exp_t;
    typedef struct {logic [3:0] btns; logic [7:0] din; logic [15:0] codes; int n;} vec_t;

    exp_t sb[$];
    exp_t e_mon;
    vec_t vecs[6];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] last_din;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Every output pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (Reset === 1'b1 && {Sample, Btns} != 4'b0) begin
            checks++;
            if (!$onehot({Sample, Btns})) begin
                failures++;
                $display("FAIL onehot cyc=%0d actual=%b", cyc, {Sample, Btns});
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d actual=%b", cyc, {Sample, Btns});
            end else begin
                e_mon = sb.pop_front();
                if (e_mon.cyc != cyc || e_mon.code != {Sample, Btns} ||
                    (e_mon.code[3] && DinOut !== e_mon.din)) begin
                    failures++;
                    $display("FAIL pulse actual cyc=%0d code=%b din=%h required cyc=%0d code=%b din=%h",
                             cyc, {Sample, Btns}, DinOut, e_mon.cyc, e_mon.code, e_mon.din);
                end
            end
        end
    end

    initial begin
        int m;
        vecs[0] = '{4'b1000, 8'h02, 16'h8000, 1};
        vecs[1] = '{4'b1111, 8'h11, 16'h8421, 4};
        vecs[2] = '{4'b0100, 8'h33, 16'h4000, 1};
        vecs[3] = '{4'b0011, 8'h44, 16'h2100, 2};
        vecs[4] = '{4'b1001, 8'hA5, 16'h8100, 2};
        vecs[5] = '{4'b0001, 8'h5A, 16'h1000, 1};
        Reset = 1'b0; Turbo = 1'b1; RawBtns = '0; RawDin = '0; last_din = '0;
        step(3);
        chk("rst_sample", 32'(Sample), 0);
        chk("rst_btns", 32'(Btns), 0);
        chk("rst_dinout", 32'(DinOut), 0);
        chk("rst_pressed", 32'(Pressed), 0);
        Reset = 1'b1;
        step(4);

        for (int v = 0; v < 6; v++) begin
            RawBtns = vecs[v].btns;
            RawDin  = vecs[v].din;
            for (int k = 0; k < vecs[v].n; k++)
                sb.push_back('{cyc + 3 + k, vecs[v].codes[15 - 4*k -: 4], vecs[v].din});
            step();
            RawBtns = '0;
            step(9);
            if (vecs[v].btns[3]) last_din = vecs[v].din;
            chk("vec_dinout", 32'(DinOut), 32'(last_din));
            chk("vec_pressed", 32'(Pressed), 0);
        end

        RawDin = 8'hFD; RawBtns = 4'b1000;
        sb.push_back('{cyc + 3, 4'b1000, 8'hFD});
        step();
        RawBtns = '0;
        step();
        RawDin = 8'h05;
        step(6);
        chk("capture_hold", 32'(DinOut), 32'hFD);
        RawBtns = 4'b1000;
        sb.push_back('{cyc + 3, 4'b1000, 8'h05});
        step();
        RawBtns = '0;
        step(6);
        chk("capture_next", 32'(DinOut), 32'h05);

        Turbo = 1'b0;
        step(4);
        foreach (vecs[j]) begin end
        RawBtns = 4'b0010; step();
        RawBtns = 4'b0000; step();
        RawBtns = 4'b0010; step();
        RawBtns = 4'b0000; step();
        RawBtns = 4'b0010;
        m = cyc + 1;
        sb.push_back('{m + 5, 4'b0010, 8'h00});
        step(5);
        chk("bounce_pressed_early", 32'(Pressed), 0);
        step();
        chk("bounce_pressed", 32'(Pressed), 32'b0010);
        step(94);
        for (int k = 0; k < 8; k++) begin
            RawBtns = (k == 3 || k == 7) ? 4'b0010 : 4'b0000;
            step();
        end
        RawBtns = 4'b0000;
        m = cyc + 1;
        step(5);
        chk("release_held", 32'(Pressed), 32'b0010);
        step();
        chk("release_done", 32'(Pressed), 0);
        step(4);

        RawBtns = 4'b0100;
        step(4);
        Reset = 1'b0;
        #1;
        chk("async_sample", 32'(Sample), 0);
        chk("async_btns", 32'(Btns), 0);
        chk("async_dinout", 32'(DinOut), 0);
        chk("async_pressed", 32'(Pressed), 0);
        step(2);
        Reset = 1'b1;
        sb.push_back('{cyc + 6, 4'b0100, 8'h00});
        step(10);
        chk("post_rst_pressed", 32'(Pressed), 32'b0100);
        chk("post_rst_dinout", 32'(DinOut), 0);
        RawBtns = '0;
        step(10);

        while (sb.size() > 0) begin
            e_mon = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_pulse required cyc=%0d code=%b actual=none", e_mon.cyc, e_mon.code);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
